// File: rtl/iob_asym_fifo_pkg.sv
// iob_asym_fifo_pkg: shared helpers for the asymmetric FIFO controller.
// Provides max/min/log2 helper macros and the functions that derive the
// lane ratios (WR, RR) and per-port address widths (W_ADDR_W, R_ADDR_W).
// Optional error flags are enabled with the macro IOB_ASYM_FIFO_ERR_EN.

`ifndef IOB_ASYM_FIFO_PKG_MACROS
`define IOB_ASYM_FIFO_PKG_MACROS
`define IOB_MAX(a, b) (((a) > (b)) ? (a) : (b))
`define IOB_MIN(a, b) (((a) < (b)) ? (a) : (b))
`define IOB_LOG2(x) $clog2(x)
`endif

package iob_asym_fifo_pkg;

    // Name of the macro that adds the sticky overflow/underflow outputs.
    localparam string ERR_EN_MACRO = "IOB_ASYM_FIFO_ERR_EN";

    // Width of the narrower port: the unit in which capacity and level count.
    function automatic int min_w(input int w_data_w, input int r_data_w);
        return `IOB_MIN(w_data_w, r_data_w);
    endfunction

    // Width of the wider port.
    function automatic int max_w(input int w_data_w, input int r_data_w);
        return `IOB_MAX(w_data_w, r_data_w);
    endfunction

    // Number of MIN_W lanes in one word of a port (WR for write, RR for read).
    function automatic int lane_ratio(input int side_w, input int other_w);
        return side_w / `IOB_MIN(side_w, other_w);
    endfunction

    // Address width of a port: one address per word of that port.
    function automatic int side_addr_w(input int addr_w, input int side_w, input int other_w);
        return addr_w - `IOB_LOG2(lane_ratio(side_w, other_w));
    endfunction

endpackage

// File: rtl/iob_asym_fifo_ptr.sv
// iob_asym_fifo_ptr: wrapping binary counter used for the FIFO write and
// read pointers. Wraps naturally modulo 2^PTR_W.

module iob_asym_fifo_ptr #(
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // Advance by one word on every accepted access; reset returns to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/iob_asym_fifo_ctrl.sv
// iob_asym_fifo_ctrl: single-clock FIFO controller for an external
// asymmetric two-port RAM (W_DATA_W-bit writes, R_DATA_W-bit reads).
// Level counts occupancy in MIN_W-bit lanes; full/empty decode the level
// register only. Define IOB_ASYM_FIFO_ERR_EN to add sticky w_ovf/r_udf.

module iob_asym_fifo_ctrl
    import iob_asym_fifo_pkg::*;
#(
    parameter int    W_DATA_W = 16,
    parameter int    R_DATA_W = 8,
    parameter int    ADDR_W   = 7,
    localparam int   W_ADDR_W = side_addr_w(ADDR_W, W_DATA_W, R_DATA_W),
    localparam int   R_ADDR_W = side_addr_w(ADDR_W, R_DATA_W, W_DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
`ifdef IOB_ASYM_FIFO_ERR_EN
    output logic                w_ovf,
    output logic                r_udf,
`endif
    output logic                ext_mem_w_en,
    output logic [W_ADDR_W-1:0] ext_mem_w_addr,
    output logic [W_DATA_W-1:0] ext_mem_w_data,
    output logic                ext_mem_r_en,
    output logic [R_ADDR_W-1:0] ext_mem_r_addr,
    input  logic [R_DATA_W-1:0] ext_mem_r_data
);

    localparam int LVL_W = ADDR_W + 1;
    localparam int WR    = lane_ratio(W_DATA_W, R_DATA_W);
    localparam int RR    = lane_ratio(R_DATA_W, W_DATA_W);
    localparam int CAP   = 1 << ADDR_W;

    localparam logic [LVL_W-1:0] WR_INC  = LVL_W'(WR);
    localparam logic [LVL_W-1:0] RR_DEC  = LVL_W'(RR);
    localparam logic [LVL_W-1:0] FULL_TH = LVL_W'(CAP - WR);

    logic                w_acc;
    logic                r_acc;
    logic [LVL_W-1:0]    level_nxt;
    logic [W_ADDR_W-1:0] wptr;
    logic [R_ADDR_W-1:0] rptr;

    // Flags come straight from the level register, never from same-cycle requests.
    assign w_full  = (level > FULL_TH);
    assign r_empty = (level < RR_DEC);

    // Reset dominates: no access is accepted while rst is high.
    assign w_acc = w_en & ~w_full & ~rst;
    assign r_acc = r_en & ~r_empty & ~rst;

    assign ext_mem_w_en   = w_acc;
    assign ext_mem_w_addr = wptr;
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = r_acc;
    assign ext_mem_r_addr = rptr;

    // The RAM registers its read data, so r_data holds until the next read.
    assign r_data = ext_mem_r_data;

    iob_asym_fifo_ptr #(
        .PTR_W(W_ADDR_W)
    ) u_wptr (
        .clk(clk),
        .rst(rst),
        .inc(w_acc),
        .ptr(wptr)
    );

    iob_asym_fifo_ptr #(
        .PTR_W(R_ADDR_W)
    ) u_rptr (
        .clk(clk),
        .rst(rst),
        .inc(r_acc),
        .ptr(rptr)
    );

    // Next occupancy: add write lanes and remove read lanes in the same cycle.
    always_comb begin
        level_nxt = level;
        if (w_acc) begin
            level_nxt = level_nxt + WR_INC;
        end
        if (r_acc) begin
            level_nxt = level_nxt - RR_DEC;
        end
    end

    // Occupancy register; reset discards everything stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            level <= level_nxt;
        end
    end

`ifdef IOB_ASYM_FIFO_ERR_EN
    // Sticky flags for requests dropped on full/empty, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_en & w_full) begin
                w_ovf <= 1'b1;
            end
            if (r_en & r_empty) begin
                r_udf <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// tb_iob_asym_fifo_ctrl: directed bench for the asymmetric FIFO controller.
// Instance A is 16-bit write / 8-bit read, instance B is 8-bit write /
// 16-bit read; each drives a small lane-addressed RAM model.

module tb_iob_asym_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: W=16, R=8
    logic        a_rst, a_w_en, a_r_en;
    logic [15:0] a_w_data;
    logic        a_w_full, a_r_empty;
    logic [7:0]  a_r_data;
    logic [7:0]  a_level;
    logic        a_mwen, a_mren;
    logic [5:0]  a_mwaddr;
    logic [15:0] a_mwdata;
    logic [6:0]  a_mraddr;
    logic [7:0]  a_mrdata;
`ifdef IOB_ASYM_FIFO_ERR_EN
    logic        a_w_ovf, a_r_udf;
`endif

    // Instance B: W=8, R=16
    logic        b_rst, b_w_en, b_r_en;
    logic [7:0]  b_w_data;
    logic        b_w_full, b_r_empty;
    logic [15:0] b_r_data;
    logic [7:0]  b_level;
    logic        b_mwen, b_mren;
    logic [6:0]  b_mwaddr;
    logic [7:0]  b_mwdata;
    logic [5:0]  b_mraddr;
    logic [15:0] b_mrdata;
`ifdef IOB_ASYM_FIFO_ERR_EN
    logic        b_w_ovf, b_r_udf;
`endif

    iob_asym_fifo_ctrl #(.W_DATA_W(16), .R_DATA_W(8), .ADDR_W(7)) dut_a (
        .clk(clk), .rst(a_rst),
        .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
        .r_en(a_r_en), .r_data(a_r_data), .r_empty(a_r_empty),
        .level(a_level),
`ifdef IOB_ASYM_FIFO_ERR_EN
        .w_ovf(a_w_ovf), .r_udf(a_r_udf),
`endif
        .ext_mem_w_en(a_mwen), .ext_mem_w_addr(a_mwaddr), .ext_mem_w_data(a_mwdata),
        .ext_mem_r_en(a_mren), .ext_mem_r_addr(a_mraddr), .ext_mem_r_data(a_mrdata)
    );

    iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(16), .ADDR_W(7)) dut_b (
        .clk(clk), .rst(b_rst),
        .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
        .r_en(b_r_en), .r_data(b_r_data), .r_empty(b_r_empty),
        .level(b_level),
`ifdef IOB_ASYM_FIFO_ERR_EN
        .w_ovf(b_w_ovf), .r_udf(b_r_udf),
`endif
        .ext_mem_w_en(b_mwen), .ext_mem_w_addr(b_mwaddr), .ext_mem_w_data(b_mwdata),
        .ext_mem_r_en(b_mren), .ext_mem_r_addr(b_mraddr), .ext_mem_r_data(b_mrdata)
    );

    // RAM models: byte lanes, lowest lane address holds the least-significant byte.
    logic [7:0] mem_a [0:127];
    logic [7:0] mem_b [0:127];

    always @(posedge clk) begin
        if (a_mwen) begin
            mem_a[{a_mwaddr, 1'b0}] <= a_mwdata[7:0];
            mem_a[{a_mwaddr, 1'b1}] <= a_mwdata[15:8];
        end
        if (a_mren) a_mrdata <= mem_a[a_mraddr];
    end

    always @(posedge clk) begin
        if (b_mwen) mem_b[b_mwaddr] <= b_mwdata;
        if (b_mren) b_mrdata <= {mem_b[{b_mraddr, 1'b1}], mem_b[{b_mraddr, 1'b0}]};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs to A after the falling edge, then settle.
    task automatic drive_a(input logic rs, input logic we, input logic [15:0] wd, input logic re);
        @(negedge clk);
        a_rst = rs; a_w_en = we; a_w_data = wd; a_r_en = re;
        #1;
    endtask

    task automatic drive_b(input logic rs, input logic we, input logic [7:0] wd, input logic re);
        @(negedge clk);
        b_rst = rs; b_w_en = we; b_w_data = wd; b_r_en = re;
        #1;
    endtask

    // ctl = {rst, w_en, r_en}; flg = {r_empty, w_full, mem_w_en, mem_r_en, check_r_data}
    typedef struct {
        logic [2:0]  ctl;
        logic [15:0] wd;
        logic [7:0]  lvl;
        logic [4:0]  flg;
        logic [7:0]  rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [2:0] ctl, input logic [15:0] wd,
                                input logic [7:0] lvl, input logic [4:0] flg,
                                input logic [7:0] rd);
        vec_t v;
        v.ctl = ctl; v.wd = wd; v.lvl = lvl; v.flg = flg; v.rd = rd;
        return v;
    endfunction

    logic [7:0] q[$];
    logic [7:0] pexp;
    logic       pend;
    logic       we_t, re_t, wacc_t, racc_t;
    logic [15:0] wd_t;
    int         written;
    int         cyc;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        a_rst = 1'b1; a_w_en = 1'b0; a_r_en = 1'b0; a_w_data = '0;
        b_rst = 1'b1; b_w_en = 1'b0; b_r_en = 1'b0; b_w_data = '0;
        repeat (2) @(negedge clk);
        b_rst = 1'b0;

        // Values are the pre-edge state seen with that row's inputs applied.
        tbl.push_back(mk(3'b111, 16'hFFFF, 8'd0, 5'b10000, 8'h00)); // in reset, requests ignored
        tbl.push_back(mk(3'b010, 16'hA1B2, 8'd0, 5'b10100, 8'h00)); // write A1B2
        tbl.push_back(mk(3'b001, 16'h0000, 8'd2, 5'b00010, 8'h00)); // level 2, read
        tbl.push_back(mk(3'b001, 16'h0000, 8'd1, 5'b00011, 8'hB2)); // low byte first
        tbl.push_back(mk(3'b000, 16'h0000, 8'd0, 5'b10001, 8'hA1)); // then high byte, empty
        tbl.push_back(mk(3'b001, 16'h0000, 8'd0, 5'b10001, 8'hA1)); // read on empty dropped
        tbl.push_back(mk(3'b011, 16'h1234, 8'd0, 5'b10101, 8'hA1)); // w+r at empty: only write
        tbl.push_back(mk(3'b010, 16'h5678, 8'd2, 5'b00100, 8'h00));
        tbl.push_back(mk(3'b011, 16'h9ABC, 8'd4, 5'b00110, 8'h00)); // w+r at level 4
        tbl.push_back(mk(3'b000, 16'h0000, 8'd5, 5'b00001, 8'h34)); // level 5
        tbl.push_back(mk(3'b001, 16'h0000, 8'd5, 5'b00011, 8'h34)); // r_data held
        tbl.push_back(mk(3'b001, 16'h0000, 8'd4, 5'b00011, 8'h12));
        tbl.push_back(mk(3'b001, 16'h0000, 8'd3, 5'b00011, 8'h78));
        tbl.push_back(mk(3'b001, 16'h0000, 8'd2, 5'b00011, 8'h56));
        tbl.push_back(mk(3'b001, 16'h0000, 8'd1, 5'b00011, 8'hBC));
        tbl.push_back(mk(3'b000, 16'h0000, 8'd0, 5'b10001, 8'h9A));
        tbl.push_back(mk(3'b010, 16'h1111, 8'd0, 5'b10101, 8'h9A));
        tbl.push_back(mk(3'b011, 16'h2222, 8'd2, 5'b00111, 8'h9A));
        tbl.push_back(mk(3'b111, 16'h3333, 8'd3, 5'b00001, 8'h11)); // reset mid-stream
        tbl.push_back(mk(3'b000, 16'h0000, 8'd0, 5'b10000, 8'h00)); // contents discarded
        tbl.push_back(mk(3'b001, 16'h0000, 8'd0, 5'b10000, 8'h00)); // read waits for new data
        tbl.push_back(mk(3'b010, 16'hA1B2, 8'd0, 5'b10100, 8'h00));
        tbl.push_back(mk(3'b001, 16'h0000, 8'd2, 5'b00010, 8'h00));
        tbl.push_back(mk(3'b001, 16'h0000, 8'd1, 5'b00011, 8'hB2));
        tbl.push_back(mk(3'b000, 16'h0000, 8'd0, 5'b10001, 8'hA1));

        foreach (tbl[i]) begin
            drive_a(tbl[i].ctl[2], tbl[i].ctl[1], tbl[i].wd, tbl[i].ctl[0]);
            chk($sformatf("row%0d_level", i), 32'(a_level), 32'(tbl[i].lvl));
            chk($sformatf("row%0d_r_empty", i), 32'(a_r_empty), 32'(tbl[i].flg[4]));
            chk($sformatf("row%0d_w_full", i), 32'(a_w_full), 32'(tbl[i].flg[3]));
            chk($sformatf("row%0d_mem_w_en", i), 32'(a_mwen), 32'(tbl[i].flg[2]));
            chk($sformatf("row%0d_mem_r_en", i), 32'(a_mren), 32'(tbl[i].flg[1]));
            if (tbl[i].flg[0]) chk($sformatf("row%0d_r_data", i), 32'(a_r_data), 32'(tbl[i].rd));
        end

        // Fill to capacity: 64 words of bytes 0..127 (write pointer sits at word 1).
        for (int i = 0; i < 64; i++) begin
            drive_a(1'b0, 1'b1, {8'(2 * i + 1), 8'(2 * i)}, 1'b0);
            if (i == 0) begin
                chk("fill_first_w_addr", 32'(a_mwaddr), 32'd1);
                chk("fill_first_w_data", 32'(a_mwdata), 32'h0100);
            end
            if (i == 63) begin
                chk("fill_126_level", 32'(a_level), 32'd126);
                chk("fill_126_w_full", 32'(a_w_full), 32'd0);
                chk("fill_126_mem_w_en", 32'(a_mwen), 32'd1);
            end
        end
        drive_a(1'b0, 1'b1, 16'hEEEE, 1'b0);
        chk("full_level", 32'(a_level), 32'd128);
        chk("full_w_full", 32'(a_w_full), 32'd1);
        chk("full_r_empty", 32'(a_r_empty), 32'd0);
        chk("full_drop_mem_w_en", 32'(a_mwen), 32'd0);
        drive_a(1'b0, 1'b1, 16'hEEEE, 1'b1);
        chk("full_wr_level", 32'(a_level), 32'd128);
        chk("full_wr_mem_w_en", 32'(a_mwen), 32'd0);
        chk("full_wr_mem_r_en", 32'(a_mren), 32'd1);
        chk("full_wr_r_addr", 32'(a_mraddr), 32'd2);
        for (int i = 1; i < 128; i++) begin
            drive_a(1'b0, 1'b0, 16'h0000, 1'b1);
            if (i == 1) begin
                chk("after_full_wr_level", 32'(a_level), 32'd127);
                chk("after_full_wr_w_full", 32'(a_w_full), 32'd1);
            end
            chk($sformatf("drain_byte%0d", i - 1), 32'(a_r_data), 32'(i - 1));
        end
        drive_a(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("drain_byte127", 32'(a_r_data), 32'd127);
        chk("drain_level", 32'(a_level), 32'd0);
        chk("drain_r_empty", 32'(a_r_empty), 32'd1);

        // Mixed traffic through three capacities with a byte-queue model.
        q.delete();
        pend = 1'b0;
        written = 0;
        cyc = 0;
        while ((written < 192 || q.size() > 0) && cyc < 4000) begin
            we_t = (written < 192) && ($urandom_range(0, 2) != 0);
            re_t = ($urandom_range(0, 3) != 0);
            wd_t = 16'($urandom);
            drive_a(1'b0, we_t, wd_t, re_t);
            if (pend) chk("traffic_r_data", 32'(a_r_data), 32'(pexp));
            chk("traffic_level", 32'(a_level), 32'(q.size()));
            wacc_t = we_t && (q.size() <= 126);
            racc_t = re_t && (q.size() >= 1);
            chk("traffic_mem_w_en", 32'(a_mwen), 32'(wacc_t));
            chk("traffic_mem_r_en", 32'(a_mren), 32'(racc_t));
            pend = racc_t;
            if (racc_t) pexp = q.pop_front();
            if (wacc_t) begin
                q.push_back(wd_t[7:0]);
                q.push_back(wd_t[15:8]);
                written++;
            end
            cyc++;
        end
        chk("traffic_completed", 32'(cyc < 4000), 32'd1);
        drive_a(1'b0, 1'b0, 16'h0000, 1'b0);
        if (pend) chk("traffic_last_r_data", 32'(a_r_data), 32'(pexp));
        chk("traffic_end_level", 32'(a_level), 32'd0);

`ifdef IOB_ASYM_FIFO_ERR_EN
        drive_a(1'b1, 1'b0, 16'h0000, 1'b0);
        drive_a(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("err_reset_w_ovf", 32'(a_w_ovf), 32'd0);
        chk("err_reset_r_udf", 32'(a_r_udf), 32'd0);
        drive_a(1'b0, 1'b0, 16'h0000, 1'b1);
        drive_a(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("err_r_udf_set", 32'(a_r_udf), 32'd1);
        chk("err_w_ovf_clear", 32'(a_w_ovf), 32'd0);
        for (int i = 0; i < 64; i++) drive_a(1'b0, 1'b1, 16'h5A5A, 1'b0);
        chk("err_r_udf_sticky", 32'(a_r_udf), 32'd1);
        drive_a(1'b0, 1'b1, 16'h5A5A, 1'b0);
        chk("err_w_ovf_before", 32'(a_w_ovf), 32'd0);
        drive_a(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("err_w_ovf_set", 32'(a_w_ovf), 32'd1);
        drive_a(1'b0, 1'b0, 16'h0000, 1'b1);
        drive_a(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("err_w_ovf_sticky", 32'(a_w_ovf), 32'd1);
        drive_a(1'b1, 1'b0, 16'h0000, 1'b0);
        drive_a(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("err_rst_w_ovf", 32'(a_w_ovf), 32'd0);
        chk("err_rst_r_udf", 32'(a_r_udf), 32'd0);
`endif

        // Narrow write, wide read: two writes make one read word.
        drive_b(1'b0, 1'b1, 8'h11, 1'b0);
        chk("b_w1_level", 32'(b_level), 32'd0);
        chk("b_w1_mem_w_en", 32'(b_mwen), 32'd1);
        chk("b_w1_w_addr", 32'(b_mwaddr), 32'd0);
        drive_b(1'b0, 1'b1, 8'h22, 1'b0);
        chk("b_w2_level", 32'(b_level), 32'd1);
        chk("b_w2_r_empty", 32'(b_r_empty), 32'd1);
        chk("b_w2_w_addr", 32'(b_mwaddr), 32'd1);
        drive_b(1'b0, 1'b0, 8'h00, 1'b1);
        chk("b_rd_level", 32'(b_level), 32'd2);
        chk("b_rd_r_empty", 32'(b_r_empty), 32'd0);
        chk("b_rd_mem_r_en", 32'(b_mren), 32'd1);
        chk("b_rd_r_addr", 32'(b_mraddr), 32'd0);
        drive_b(1'b0, 1'b0, 8'h00, 1'b0);
        chk("b_r_data", 32'(b_r_data), 32'h2211);
        chk("b_end_level", 32'(b_level), 32'd0);
        chk("b_end_r_empty", 32'(b_r_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_asym_fifo_ctrl.md
# iob_asym_fifo_ctrl

Single-clock FIFO controller that sits directly upstream of the asymmetric two-port RAM: it accepts writes of W_DATA_W bits and reads of R_DATA_W bits. It generates that RAM's write/read enables and addresses, and tracks occupancy and full/empty. The RAM stays external, so one controller serves any RAM macro with the same port contract.

## Interface
- W_DATA_W, 16, write word width
- R_DATA_W, 8, read word width; max/min of the two widths is a power of two
- ADDR_W, 7, log2 of capacity in MIN_W-bit units (MIN_W = min(W_DATA_W, R_DATA_W)); ADDR_W > log2(ratio)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- w_en  in  1  write request
- w_data  in  W_DATA_W  write data
- w_full  out  1  no room for one write word
- r_en  in  1  read request
- r_data  out  R_DATA_W  read data, valid cycle after accepted read
- r_empty  out  1  less than one read word stored
- level  out  ADDR_W+1  occupancy in MIN_W units
- ext_mem_w_en  out  1  RAM write enable
- ext_mem_w_addr  out  W_ADDR_W  RAM write address (ADDR_W - log2(W_DATA_W/MIN_W))
- ext_mem_w_data  out  W_DATA_W  RAM write data
- ext_mem_r_en  out  1  RAM read enable
- ext_mem_r_addr  out  R_ADDR_W  RAM read address (ADDR_W - log2(R_DATA_W/MIN_W))
- ext_mem_r_data  in  R_DATA_W  RAM read data (registered in RAM, 1-cycle latency)

## Operation
- WR = W_DATA_W/MIN_W, RR = R_DATA_W/MIN_W, CAP = 2^ADDR_W.
- Write accepted iff w_en & ~w_full: ext_mem_w_en=1, ext_mem_w_addr=wptr, ext_mem_w_data=w_data; wptr += 1 (wraps mod 2^W_ADDR_W).
- Read accepted iff r_en & ~r_empty: ext_mem_r_en=1, ext_mem_r_addr=rptr; rptr += 1 (wraps mod 2^R_ADDR_W).
- Requests on full (write) / empty (read) are dropped: no RAM access, no pointer/level change.
- level register: +WR on accepted write, -RR on accepted read, +WR-RR on both, same cycle.
- w_full = (level > CAP-WR); r_empty = (level < RR); both decoded from the level register only. They do not depend on same-cycle requests.
- Lane order: lowest-addressed MIN_W slice = least-significant bits. For W>R, the first read after writing X returns X[R_DATA_W-1:0]. For W<R, the first write lands in r_data[W_DATA_W-1:0].
- r_data = ext_mem_r_data passthrough. Contents are undefined until the first accepted read completes.

## Timing
- Reset values: wptr=0, rptr=0, level=0, r_empty=1, w_full=0, ext_mem_w_en=0, ext_mem_r_en=0.
- rst dominates: while rst=1, all requests are ignored and the enables are forced 0.
- Reset mid-operation discards the contents. The first read after reset waits for new writes.
- Write at edge N: level and r_empty update at edge N. A read issued in cycle N+1 returns data after edge N+1.
- Read latency: accepted read in cycle N, r_data valid in cycle N+1, held until the next accepted read.
- Simultaneous read and write at full or empty: each side is judged on the pre-edge level. A write while full is dropped even if a read is accepted in the same cycle.
- Pointer wrap needs no special handling. Level never exceeds CAP and never goes below 0.

## Configuration
- IOB_ASYM_FIFO_ERR_EN: when defined, adds outputs w_ovf and r_udf (1 bit each, reset 0).
  - w_ovf goes high after edge N if w_en & w_full in cycle N; r_udf likewise for r_en & r_empty.
  - Both are sticky until rst.
- Undefined: ports absent; dropped requests are silent.

## Structure
- Shared package/header: max/min/log2 helper macros, the derived WR, RR, W_ADDR_W and R_ADDR_W localparams, and the error-flag macro name.
- One natural sub-module, iob_asym_fifo_ptr: a wrapping binary counter with parameterised width, increment enable and synchronous reset. It is instantiated twice, for wptr and rptr.
- Level and flag logic stay in the top.

## Test plan
- W=16,R=8,ADDR_W=7: after rst, write 0xA1B2. Next cycle level=2, r_empty=0. Two reads return 0xB2 then 0xA1, then level=0 and r_empty=1.
- W=8,R=16: write 0x11 then 0x22. r_empty=1 after the first write and 0 after the second. One read returns 0x2211.
- W=16,R=8: write 64 words. level=128, w_full=1. A 65th write is dropped: ext_mem_w_en=0, level unchanged.
- Simultaneous read and write at level=4 (W=16,R=8): level becomes 5. Run 3×CAP traffic and check data order through pointer wrap.
- Assert rst mid-stream with w_en=r_en=1. Next cycle level=0, r_empty=1, w_full=0, and no RAM enables are asserted during rst.
- With IOB_ASYM_FIFO_ERR_EN: a read on empty sets r_udf=1, which stays high until rst; w_ovf is tested the same way on full.
